// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_pkg
// Purpose : Shared types and constants for the video timing controller:
//           register map, 640x480 default timing, commit FSM states.
// Revision: 1.0 - initial release
// ============================================================================
package video_timing_pkg;

   localparam int CW = 12;

   localparam logic [3:0] ADDR_H_TOTAL = 4'd0;
   localparam logic [3:0] ADDR_H_SYNC  = 4'd1;
   localparam logic [3:0] ADDR_H_START = 4'd2;
   localparam logic [3:0] ADDR_H_END   = 4'd3;
   localparam logic [3:0] ADDR_V_TOTAL = 4'd4;
   localparam logic [3:0] ADDR_V_SYNC  = 4'd5;
   localparam logic [3:0] ADDR_V_START = 4'd6;
   localparam logic [3:0] ADDR_V_END   = 4'd7;
   localparam logic [3:0] ADDR_STATUS  = 4'd8;

   // All timing values are stored as (value - 1).
   localparam logic [CW-1:0] H_TOTAL_DEF = 12'd799;
   localparam logic [CW-1:0] H_SYNC_DEF  = 12'd95;
   localparam logic [CW-1:0] H_START_DEF = 12'd141;
   localparam logic [CW-1:0] H_END_DEF   = 12'd781;
   localparam logic [CW-1:0] V_TOTAL_DEF = 12'd524;
   localparam logic [CW-1:0] V_SYNC_DEF  = 12'd1;
   localparam logic [CW-1:0] V_START_DEF = 12'd34;
   localparam logic [CW-1:0] V_END_DEF   = 12'd514;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_APPLY   = 2'd2
   } commit_state_e;

   typedef struct packed {
      logic [CW-1:0] h_total;
      logic [CW-1:0] h_sync;
      logic [CW-1:0] h_start;
      logic [CW-1:0] h_end;
      logic [CW-1:0] v_total;
      logic [CW-1:0] v_sync;
      logic [CW-1:0] v_start;
      logic [CW-1:0] v_end;
   } timing_t;

   function automatic logic timing_legal(input timing_t t);
      return (t.h_sync < t.h_start) && (t.h_start < t.h_end) && (t.h_end <= t.h_total) &&
             (t.v_sync < t.v_start) && (t.v_start < t.v_end) && (t.v_end <= t.v_total);
   endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_counter.sv
`default_nettype none
// ============================================================================
// Module  : video_timing_counter
// Purpose : Pixel/line counters with registered hs/vs/de and line/frame
//           strobes; flags the frame boundary to the commit logic.
// Revision: 1.0 - initial release
// ============================================================================
module video_timing_counter
   import video_timing_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  timing_t       active_i,
   output logic [CW-1:0] h_pos_o,
   output logic [CW-1:0] v_pos_o,
   output logic          hs_o,
   output logic          vs_o,
   output logic          de_o,
   output logic          line_start_o,
   output logic          frame_start_o,
   output logic          boundary_o
);

   logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CW-1:0] h_pos_q, v_pos_q;
   logic          hs_q, vs_q, de_q, line_start_q, frame_start_q;
   logic          hs_d, vs_d, de_d, line_start_d, frame_start_d;
   logic          h_wrap;

   assign h_wrap     = (h_cnt_q == active_i.h_total);
   assign boundary_o = h_wrap && (v_cnt_q == active_i.v_total);

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == active_i.v_total) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_comb begin
      hs_d          = (h_cnt_q > active_i.h_sync);
      vs_d          = (v_cnt_q > active_i.v_sync);
      de_d          = (h_cnt_q > active_i.h_start) && (h_cnt_q <= active_i.h_end) &&
                      (v_cnt_q > active_i.v_start) && (v_cnt_q <= active_i.v_end);
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // Outputs describe the counter state of the previous cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         h_pos_q       <= '0;
         v_pos_q       <= '0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         h_pos_q       <= h_cnt_q;
         v_pos_q       <= v_cnt_q;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_pos_o       = h_pos_q;
   assign v_pos_o       = v_pos_q;
   assign hs_o          = hs_q;
   assign vs_o          = vs_q;
   assign de_o          = de_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : video_mode_ctrl
// Purpose : Shadow timing registers with frame-atomic commit, plus the
//           timing generator. Optional VMC_READBACK_EN adds cfg_rdata.
// Revision: 1.0 - initial release
// ============================================================================
module video_mode_ctrl #(
   parameter int            CW        = 12,
   parameter logic [CW-1:0] H_TOTAL_D = video_timing_pkg::H_TOTAL_DEF,
   parameter logic [CW-1:0] H_SYNC_D  = video_timing_pkg::H_SYNC_DEF,
   parameter logic [CW-1:0] H_START_D = video_timing_pkg::H_START_DEF,
   parameter logic [CW-1:0] H_END_D   = video_timing_pkg::H_END_DEF,
   parameter logic [CW-1:0] V_TOTAL_D = video_timing_pkg::V_TOTAL_DEF,
   parameter logic [CW-1:0] V_SYNC_D  = video_timing_pkg::V_SYNC_DEF,
   parameter logic [CW-1:0] V_START_D = video_timing_pkg::V_START_DEF,
   parameter logic [CW-1:0] V_END_D   = video_timing_pkg::V_END_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_wr,
   input  logic [3:0]    cfg_addr,
   input  logic [CW-1:0] cfg_wdata,
   input  logic          cfg_commit,
   output logic          cfg_busy,
   output logic          cfg_err,
   output logic [CW-1:0] h_pos,
   output logic [CW-1:0] v_pos,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic          line_start,
   output logic          frame_start
`ifdef VMC_READBACK_EN
   ,
   output logic [CW-1:0] cfg_rdata
`endif
);

   import video_timing_pkg::*;

   localparam timing_t DEFAULTS = '{
      h_total: H_TOTAL_D, h_sync: H_SYNC_D, h_start: H_START_D, h_end: H_END_D,
      v_total: V_TOTAL_D, v_sync: V_SYNC_D, v_start: V_START_D, v_end: V_END_D
   };

   commit_state_e state_q, state_d;
   timing_t       shadow_q, shadow_d, active_q, active_d;
   logic          err_q, err_d;
   logic          boundary;

   always_comb begin
      shadow_d = shadow_q;
      if (cfg_wr) begin
         case (cfg_addr)
            ADDR_H_TOTAL: shadow_d.h_total = cfg_wdata;
            ADDR_H_SYNC:  shadow_d.h_sync  = cfg_wdata;
            ADDR_H_START: shadow_d.h_start = cfg_wdata;
            ADDR_H_END:   shadow_d.h_end   = cfg_wdata;
            ADDR_V_TOTAL: shadow_d.v_total = cfg_wdata;
            ADDR_V_SYNC:  shadow_d.v_sync  = cfg_wdata;
            ADDR_V_START: shadow_d.v_start = cfg_wdata;
            ADDR_V_END:   shadow_d.v_end   = cfg_wdata;
            default:      ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
         ST_PENDING: if (boundary)   state_d = ST_APPLY;
         ST_APPLY:   state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // The copy reads the pre-write shadow, so a write in the APPLY cycle waits for the next commit.
   always_comb begin
      active_d = active_q;
      err_d    = err_q;
      if (state_q == ST_APPLY) begin
         if (timing_legal(shadow_q)) begin
            active_d = shadow_q;
            err_d    = 1'b0;
         end else begin
            err_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         shadow_q <= DEFAULTS;
         active_q <= DEFAULTS;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         err_q    <= err_d;
      end
   end

   assign cfg_busy = (state_q != ST_IDLE);
   assign cfg_err  = err_q;

`ifdef VMC_READBACK_EN
   logic [CW-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = '0;
      case (cfg_addr)
         ADDR_H_TOTAL: rdata_d = shadow_q.h_total;
         ADDR_H_SYNC:  rdata_d = shadow_q.h_sync;
         ADDR_H_START: rdata_d = shadow_q.h_start;
         ADDR_H_END:   rdata_d = shadow_q.h_end;
         ADDR_V_TOTAL: rdata_d = shadow_q.v_total;
         ADDR_V_SYNC:  rdata_d = shadow_q.v_sync;
         ADDR_V_START: rdata_d = shadow_q.v_start;
         ADDR_V_END:   rdata_d = shadow_q.v_end;
         ADDR_STATUS:  rdata_d = {{(CW-2){1'b0}}, err_q, cfg_busy};
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign cfg_rdata = rdata_q;
`endif

   video_timing_counter u_counter (
      .clk           (clk),
      .reset         (reset),
      .active_i      (active_q),
      .h_pos_o       (h_pos),
      .v_pos_o       (v_pos),
      .hs_o          (hs),
      .vs_o          (vs),
      .de_o          (de),
      .line_start_o  (line_start),
      .frame_start_o (frame_start),
      .boundary_o    (boundary)
   );

endmodule
`default_nettype wire

// File: tb/tb_video_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_mode_ctrl
// Purpose : Scoreboard bench for video_mode_ctrl with a small-frame timing
//           set and a behavioural frame model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_video_mode_ctrl;

   localparam int CW = 12;
   localparam int HT = 19, HS = 2, HST = 4, HE = 15;
   localparam int VT = 11, VS = 1, VST = 2, VE = 9;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_wr = 1'b0;
   logic [3:0]    cfg_addr = '0;
   logic [CW-1:0] cfg_wdata = '0;
   logic          cfg_commit = 1'b0;
   logic          cfg_busy, cfg_err, hs, vs, de, line_start, frame_start;
   logic [CW-1:0] h_pos, v_pos;
`ifdef VMC_READBACK_EN
   logic [CW-1:0] cfg_rdata;
`endif

   always #5 clk = ~clk;

   video_mode_ctrl #(
      .CW(CW),
      .H_TOTAL_D(12'(HT)), .H_SYNC_D(12'(HS)), .H_START_D(12'(HST)), .H_END_D(12'(HE)),
      .V_TOTAL_D(12'(VT)), .V_SYNC_D(12'(VS)), .V_START_D(12'(VST)), .V_END_D(12'(VE))
   ) dut (
      .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .h_pos(h_pos), .v_pos(v_pos), .hs(hs), .vs(vs), .de(de),
      .line_start(line_start), .frame_start(frame_start)
`ifdef VMC_READBACK_EN
      , .cfg_rdata(cfg_rdata)
`endif
   );

   typedef struct {
      logic [CW-1:0] h, v, rd;
      logic          hs, vs, de, ls, fs, busy, err;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: active/shadow sets as plain arrays indexed by register address.
   int m_act[8], m_shd[8], m_def[8];
   int m_hc, m_vc, m_phase, m_err;

   task automatic model_step(input bit r, input bit w, input int a, input int d, input bit c);
      obs_t o;
      bit   bnd;
      if (r) begin
         o.h = '0; o.v = '0; o.rd = '0;
         o.hs = 1'b1; o.vs = 1'b1; o.de = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
         o.busy = 1'b0; o.err = 1'b0;
         m_act = m_def; m_shd = m_def;
         m_hc = 0; m_vc = 0; m_phase = 0; m_err = 0;
      end else begin
         o.h  = CW'(m_hc);
         o.v  = CW'(m_vc);
         o.hs = (m_hc <= m_act[1]) ? 1'b0 : 1'b1;
         o.vs = (m_vc <= m_act[5]) ? 1'b0 : 1'b1;
         o.de = (m_hc > m_act[2] && m_hc <= m_act[3] && m_vc > m_act[6] && m_vc <= m_act[7]);
         o.ls = (m_hc == 0);
         o.fs = (m_hc == 0 && m_vc == 0);
         if (a < 8)       o.rd = CW'(m_shd[a]);
         else if (a == 8) o.rd = CW'(m_err * 2 + ((m_phase != 0) ? 1 : 0));
         else             o.rd = '0;
         bnd = (m_hc == m_act[0]) && (m_vc == m_act[4]);
         if (m_hc == m_act[0]) begin
            m_hc = 0;
            m_vc = (m_vc == m_act[4]) ? 0 : m_vc + 1;
         end else begin
            m_hc = m_hc + 1;
         end
         if (m_phase == 2) begin
            if (m_shd[1] < m_shd[2] && m_shd[2] < m_shd[3] && m_shd[3] <= m_shd[0] &&
                m_shd[5] < m_shd[6] && m_shd[6] < m_shd[7] && m_shd[7] <= m_shd[4]) begin
               m_act = m_shd;
               m_err = 0;
            end else begin
               m_err = 1;
            end
            m_phase = 0;
         end else if (m_phase == 1) begin
            if (bnd) m_phase = 2;
         end else if (c) begin
            m_phase = 1;
         end
         if (w && a < 8) m_shd[a] = d;
         o.busy = (m_phase != 0);
         o.err  = (m_err != 0);
      end
      exp_q.push_back(o);
   endtask

   task automatic cyc(input bit r, input bit w, input int a, input int d, input bit c);
      @(negedge clk);
      reset      = r;
      cfg_wr     = w;
      cfg_addr   = 4'(a);
      cfg_wdata  = CW'(d);
      cfg_commit = c;
      model_step(r, w, a, d, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic wr(input int a, input int d);
      cyc(1'b0, 1'b1, a, d, 1'b0);
   endtask

   task automatic commit();
      cyc(1'b0, 1'b0, 0, 0, 1'b1);
   endtask

   task automatic timeout_fail(input string what);
      checks++;
      errors++;
      $display("FAIL %s: wait expired, required condition never reached", what);
   endtask

   task automatic wait_boundary(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim; i++) begin
         if (m_hc == m_act[0] && m_vc == m_act[4]) begin ok = 1; break; end
         idle(1);
      end
      if (!ok) timeout_fail("wait_boundary");
   endtask

   task automatic wait_phase(input int p, input int lim);
      bit ok = 0;
      for (int i = 0; i < lim; i++) begin
         if (m_phase == p) begin ok = 1; break; end
         idle(1);
      end
      if (!ok) timeout_fail("wait_phase");
   endtask

   task automatic wr_legal_set();
      int s, st, e, t;
      s  = int'($urandom_range(0, 3));
      st = s + int'($urandom_range(1, 3));
      e  = st + int'($urandom_range(1, 10));
      t  = e + int'($urandom_range(0, 5));
      wr(0, t); wr(1, s); wr(2, st); wr(3, e);
      s  = int'($urandom_range(0, 2));
      st = s + int'($urandom_range(1, 3));
      e  = st + int'($urandom_range(1, 8));
      t  = e + int'($urandom_range(0, 4));
      wr(4, t); wr(5, s); wr(6, st); wr(7, e);
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         int p;
         p = int'($urandom_range(0, 999));
         if (p < 2)        cyc(1'b1, 1'b0, 0, 0, 1'b0);
         else if (p < 5)   begin wr_legal_set(); commit(); end
         else if (p < 20)  cyc(1'b0, 1'b0, int'($urandom_range(0, 15)), 0, 1'b1);
         else if (p < 200) cyc(1'b0, 1'b1, int'($urandom_range(0, 15)),
                               int'($urandom_range(1, 30)), p < 40);
         else              cyc(1'b0, 1'b0, int'($urandom_range(0, 15)), 0, 1'b0);
      end
   endtask

   // Monitor: every cycle after the first stimulus is an observable output.
   initial begin
      obs_t e;
      bit   rd_bad;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef VMC_READBACK_EN
            rd_bad = (cfg_rdata !== e.rd);
`else
            rd_bad = 1'b0;
`endif
            checks++;
            if (h_pos !== e.h || v_pos !== e.v || hs !== e.hs || vs !== e.vs || de !== e.de ||
                line_start !== e.ls || frame_start !== e.fs || cfg_busy !== e.busy ||
                cfg_err !== e.err || rd_bad) begin
               errors++;
               $display("FAIL outputs @%0t: got h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b busy=%b err=%b rd_bad=%b; exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b busy=%b err=%b rd=%0d",
                        $time, h_pos, v_pos, hs, vs, de, line_start, frame_start, cfg_busy, cfg_err, rd_bad,
                        e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs, e.busy, e.err, e.rd);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      m_def = '{HT, HS, HST, HE, VT, VS, VST, VE};
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      idle(2 * 240 + 10);

      // Longer lines committed mid-frame.
      wr(0, 29); wr(3, 25);
      idle(60);
      commit();
      wait_phase(0, 1000);
      idle(2 * 360);

      // Illegal set keeps timing and sets the sticky error; a legal one clears it.
      wr(1, 10);
      commit();
      wait_phase(0, 1000);
      idle(20);
      wr(1, 2);
      commit();
      wait_phase(0, 1000);
      idle(20);

      // Commit exactly on the boundary cycle applies one frame later.
      wr(4, 13);
      wait_boundary(1000);
      commit();
      wait_phase(0, 1000);
      idle(2 * 420);

      // Write landing in the APPLY cycle is deferred to the next commit.
      wr(1, 3);
      commit();
      wait_phase(2, 1000);
      cyc(1'b0, 1'b1, 0, 35, 1'b0);
      idle(30);
      commit();
      wait_phase(0, 1000);
      idle(600);

      // Readback of a shadow register and the status word while pending.
      wr(5, 3);
      cyc(1'b0, 1'b0, 5, 0, 1'b0);
      cyc(1'b0, 1'b0, 5, 0, 1'b0);
      commit();
      cyc(1'b0, 1'b0, 8, 0, 1'b0);
      cyc(1'b0, 1'b0, 8, 0, 1'b0);
      wait_phase(0, 1000);
      cyc(1'b0, 1'b0, 8, 0, 1'b0);

      // Reset while a modified shadow set is pending.
      wr(0, 40); wr(4, 20);
      commit();
      idle(50);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b0, 0, 0, 1'b0);
      idle(2 * 240 + 5);

      run_random(6000);
      idle(5);

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Runtime configuration and sequencing controller for the HDMI video timing path. It holds the eight horizontal/vertical timing constants in shadow registers that software-facing logic writes. A commit request applies the shadow set atomically at the next frame boundary. The block also runs the pixel/line counters and produces registered hs/vs/de plus frame/line strobes for the downstream pattern/pixel source.

## Interface
Parameters:
- CW, 12, width of all timing values and counters.
- Power-on timing defaults, all (value − 1) encoded: H_TOTAL_D 799, H_SYNC_D 95, H_START_D 141, H_END_D 781, V_TOTAL_D 524, V_SYNC_D 1, V_START_D 34, V_END_D 514.

Ports:
- clk  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- cfg_wr  in  1  write strobe into the shadow register at cfg_addr.
- cfg_addr  in  4  register index: 0 h_total, 1 h_sync, 2 h_start, 3 h_end, 4 v_total, 5 v_sync, 6 v_start, 7 v_end; 8–15 ignored.
- cfg_wdata  in  CW  write data.
- cfg_commit  in  1  single-cycle request to apply the shadow set.
- cfg_busy  out  1  commit pending.
- cfg_err  out  1  sticky: last commit was rejected.
- h_pos, v_pos  out  CW each  registered counter values.
- hs, vs  out  1 each  active-low syncs.
- de  out  1  active-video enable.
- line_start, frame_start  out  1 each  single-cycle strobes.

## Operation
- Counters: h_cnt steps 0..h_total, then wraps to 0 and v_cnt increments; v_cnt steps 0..v_total, then wraps to 0. Boundary = (h_cnt==h_total && v_cnt==v_total).
- Decode from the active set: hs=0 when h_cnt≤h_sync; vs=0 when v_cnt≤v_sync; de=1 when h_start<h_cnt≤h_end and v_start<v_cnt≤v_end. line_start=1 when h_cnt==0; frame_start=1 when h_cnt==0 && v_cnt==0.
- Shadow writes are accepted in every state. Within a cycle's writes, the last one wins. Writes to addr 8–15 are dropped.
- The commit FSM has three states:
  - IDLE: cfg_commit moves it to PENDING.
  - PENDING: a boundary cycle moves it to APPLY. cfg_commit in this state has no further effect.
  - APPLY: lasts one cycle, then returns to IDLE.
- cfg_busy = (state≠IDLE).
- APPLY validates the shadow set. The set is legal only if all of these hold: h_sync<h_start<h_end≤h_total and v_sync<v_start<v_end≤v_total.
  - Legal set: active ← shadow and cfg_err ← 0.
  - Illegal set: the active set is kept and cfg_err ← 1.
- The counters wrap to 0 on the boundary cycle regardless, so the new frame starts with the new set. No partial frame is ever produced.
- Simultaneous events:
  - cfg_commit in the same cycle as a boundary while IDLE: the FSM enters PENDING and applies at the following boundary.
  - cfg_wr in the APPLY cycle: lands in shadow after the copy; it is not applied until the next commit.
- Reset mid-frame or mid-commit: the active and shadow sets return to the defaults, counters go to 0, state to IDLE, and the pending commit is discarded.

## Timing
- All outputs are registered, one cycle after the counter state they describe. All outputs are mutually aligned.
- Reset values: h_pos=0, v_pos=0, hs=1, vs=1, de=0, line_start=0, frame_start=0, cfg_busy=0, cfg_err=0.
- First output cycle after reset deassertion: h_pos=0, v_pos=0, hs=0, vs=0, frame_start=1.
- cfg_busy rises the cycle after cfg_commit. It falls the cycle after APPLY.
- A new set is visible at outputs with frame_start, one cycle after the boundary.
- Commit-to-apply latency is at most one frame plus 2 cycles.

## Configuration
- VMC_READBACK_EN defined:
  - Adds output cfg_rdata [CW-1:0], the registered shadow value at cfg_addr, one-cycle latency.
  - Addr 8 returns the status word {cfg_err, cfg_busy} zero-extended. Addr 9–15 return 0.
  - Reset value of cfg_rdata is 0.
- VMC_READBACK_EN undefined: the port and the readback mux are absent. Behaviour is otherwise identical.

## Structure
- Package video_timing_pkg contains:
  - register address constants (0–8) and CW;
  - the default 640×480 timing values;
  - the commit-FSM state enum;
  - a packed struct for the 8-field timing set.
- Sub-module video_timing_counter: the h/v counters and the registered decode.
  - Inputs: the active set struct and clk/reset.
  - Outputs: counters, syncs, de, strobes, and a boundary flag to the FSM.

## Test plan
- Reset, then run 800×525 cycles → frame_start pulses exactly every 420000 cycles, each line has 640 de cycles, and each frame has 480 de lines.
- Write h_total=999, h_end=981, then commit at mid-frame → cfg_busy=1 until the boundary, the old 800-cycle lines continue until then, and after frame_start lines are 1000 cycles.
- Write h_sync=200 (>h_start=141), then commit → at the boundary cfg_err=1, timing is unchanged, and cfg_busy falls. A following legal commit clears cfg_err.
- cfg_commit on the exact boundary cycle → no apply at that boundary; the apply happens at the next one, 420000 cycles later.
- Assert reset while PENDING with modified shadow → cfg_busy=0, defaults are restored, and the first frame after reset uses 799/524 timing.
- With VMC_READBACK_EN: write addr 5 = 3, then read addr 5 → cfg_rdata=3 one cycle later. Read addr 8 while pending → cfg_rdata=1.
